// File: rtl/pca_pkg.sv
// pca_pkg: shared definitions for pipelined_chunk_adder.
//   nstages()   : number of pipeline stages for a WIDTH/CHUNK split
//   stage_ctl_t : per-stage control record (valid, registered slice carry,
//                 and operand sign bits when PIPELINED_CHUNK_ADDER_OVF_EN
//                 is defined)
package pca_pkg;

  function automatic int nstages(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 0;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit ripple adder built from chained full-adder
// cells (each full adder is two half adders plus an OR on the carries).
// Ports:
//   a_i, b_i : W-bit operands
//   cin_i    : carry into bit 0
//   sum_o    : W-bit sum
//   cout_o   : carry out of bit W-1
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic hs;
    logic hc1;
    logic hc2;
    assign hs       = a_i[i] ^ b_i[i];
    assign hc1      = a_i[i] & b_i[i];
    assign sum_o[i] = hs ^ c[i];
    assign hc2      = hs & c[i];
    assign c[i+1]   = hc1 | hc2;
  end

  assign cout_o = c[W];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: WIDTH-bit a+b+cin split into CHUNK-bit ripple slices,
// one slice per pipeline stage, carry registered between stages.
// Optional build macro: PIPELINED_CHUNK_ADDER_OVF_EN adds the ovf output
// (two's-complement signed overflow, aligned with sum).
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = global advance)
//   a, b, cin            : operands and carry-in
//   out_valid / out_ready: result handshake
//   sum, cout            : result modulo 2^WIDTH and carry out of the MSB
//   ovf                  : signed overflow (only with the macro defined)
module pipelined_chunk_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTAGES = nstages(WIDTH, CHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || NSTAGES < 1) begin : g_bad_cfg
    $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // One global advance: the whole pipe moves together or holds together,
  // so bubbles are kept rather than collapsed.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  stage_ctl_t       ctl_q [NSTAGES];
  logic [WIDTH-1:0] sum_q [NSTAGES];
  logic [WIDTH-1:0] a_q   [NSTAGES];
  logic [WIDTH-1:0] b_q   [NSTAGES];

  logic [CHUNK-1:0] ca [NSTAGES];
  logic [CHUNK-1:0] cb [NSTAGES];
  logic [CHUNK-1:0] cs [NSTAGES];
  logic             ci [NSTAGES];
  logic             co [NSTAGES];

  // Stage 0 slices the live inputs; stage k slices the operands carried in
  // stage k-1 and takes its registered carry.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign ca[k] = a[CHUNK-1:0];
      assign cb[k] = b[CHUNK-1:0];
      assign ci[k] = cin;
    end else begin : g_next
      assign ca[k] = a_q[k-1][k*CHUNK +: CHUNK];
      assign cb[k] = b_q[k-1][k*CHUNK +: CHUNK];
      assign ci[k] = ctl_q[k-1].carry;
    end

    chunk_adder #(.W(CHUNK)) u_chunk (
      .a_i   (ca[k]),
      .b_i   (cb[k]),
      .cin_i (ci[k]),
      .sum_o (cs[k]),
      .cout_o(co[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv) begin
      ctl_q[0].valid <= in_valid;
      ctl_q[0].carry <= co[0];
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
      ctl_q[0].a_msb <= a[WIDTH-1];
      ctl_q[0].b_msb <= b[WIDTH-1];
`endif
      sum_q[0] <= WIDTH'(cs[0]);
      a_q[0]   <= a;
      b_q[0]   <= b;
      for (int k = 1; k < NSTAGES; k++) begin
        ctl_q[k].valid <= ctl_q[k-1].valid;
        ctl_q[k].carry <= co[k];
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
        ctl_q[k].a_msb <= ctl_q[k-1].a_msb;
        ctl_q[k].b_msb <= ctl_q[k-1].b_msb;
`endif
        // Lower sum bits pass through; this stage's slice overrides its chunk.
        sum_q[k]                    <= sum_q[k-1];
        sum_q[k][k*CHUNK +: CHUNK]  <= cs[k];
        a_q[k]                      <= a_q[k-1];
        b_q[k]                      <= b_q[k-1];
      end
    end
  end

  assign out_valid = ctl_q[NSTAGES-1].valid;
  assign sum       = sum_q[NSTAGES-1];
  assign cout      = ctl_q[NSTAGES-1].carry;

`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
  assign ovf = (ctl_q[NSTAGES-1].a_msb == ctl_q[NSTAGES-1].b_msb) &
               (sum_q[NSTAGES-1][WIDTH-1] != ctl_q[NSTAGES-1].a_msb);
`endif

endmodule
